// File: rtl/drag_image_ctl_pkg.sv
// drag_image_ctl_pkg
//   Shared definitions for the VGA pipeline blocks: default screen
//   geometry, coordinate widths and the drag-controller state encoding.
package drag_image_ctl_pkg;

  // Default visible screen geometry (800x600).
  localparam int SCREEN_W_DEF = 800;
  localparam int SCREEN_H_DEF = 600;

  // Unsigned screen coordinates and signed offset/target arithmetic widths.
  localparam int COORD_W = 12;
  localparam int OFF_W   = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GRAB = 2'd1,
    ST_DRAG = 2'd2
  } drag_state_t;

endpackage

// File: rtl/drag_image_ctl_clamp_coord.sv
// clamp_coord
//   Clamps a 13-bit signed coordinate into the unsigned range [0, MAX]
//   and returns it as a 12-bit screen coordinate.
//   Ports:
//     val  in  13-bit signed coordinate
//     res  out 12-bit clamped coordinate
module clamp_coord
  import drag_image_ctl_pkg::*;
#(
  parameter int MAX = 672
) (
  input  logic signed [OFF_W-1:0]   val,
  output logic        [COORD_W-1:0] res
);

  localparam logic signed [OFF_W-1:0] MAX_S = OFF_W'(MAX);
  localparam logic [COORD_W-1:0]      MAX_U = COORD_W'(MAX);

  always_comb begin
    res = val[COORD_W-1:0];
    if (val < 0) begin
      res = '0;
    end else if (val > MAX_S) begin
      res = MAX_U;
    end
  end

endmodule

// File: rtl/drag_image_ctl.sv
// drag_image_ctl
//   Lets the mouse drag an image around the screen. A click on the image
//   (rect_clicked with the left button held) grabs it and records the
//   pointer-to-corner offset; while dragging, the image corner follows the
//   pointer minus that offset, clamped to the screen, and is only updated
//   once per frame at the start of vertical blanking so nothing tears.
//   Ports:
//     pclk, rst               clock, synchronous active-high reset
//     vcount_in, hcount_in    raster position (frame tick detection)
//     xpos_mouse, ypos_mouse  pointer coordinates
//     mouse_left              left button level
//     rect_clicked            click-hit flag from the click detector
//     xpos, ypos              registered image top-left corner
//     dragging                registered, high while the state is DRAG
//     state_dbg               current FSM state, for observation
module drag_image_ctl
  import drag_image_ctl_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int RECT_W   = 128,
  parameter int RECT_H   = 128,
  parameter int INIT_X   = 336,
  parameter int INIT_Y   = 236
) (
  input  logic                pclk,
  input  logic                rst,
  input  logic [10:0]         vcount_in,
  input  logic [10:0]         hcount_in,
  input  logic [COORD_W-1:0]  xpos_mouse,
  input  logic [COORD_W-1:0]  ypos_mouse,
  input  logic                mouse_left,
  input  logic                rect_clicked,
  output logic [COORD_W-1:0]  xpos,
  output logic [COORD_W-1:0]  ypos,
  output logic                dragging,
  output logic [1:0]          state_dbg
);

  drag_state_t state, state_nxt;

  logic signed [OFF_W-1:0] off_x, off_y;
  logic signed [OFF_W-1:0] mouse_x_s, mouse_y_s;
  logic signed [OFF_W-1:0] tgt_x, tgt_y;
  logic [COORD_W-1:0]      clamp_x, clamp_y;
  logic                    frame_tick;
  logic                    grab_now;
  logic                    update_pos;

  // First pixel of the first blanking line: exactly one cycle per frame.
  assign frame_tick = (vcount_in == 11'(SCREEN_H)) && (hcount_in == 11'd0);

  assign mouse_x_s = signed'({1'b0, xpos_mouse});
  assign mouse_y_s = signed'({1'b0, ypos_mouse});
  assign tgt_x     = mouse_x_s - off_x;
  assign tgt_y     = mouse_y_s - off_y;

  clamp_coord #(.MAX(SCREEN_W - RECT_W)) u_clamp_x (.val(tgt_x), .res(clamp_x));
  clamp_coord #(.MAX(SCREEN_H - RECT_H)) u_clamp_y (.val(tgt_y), .res(clamp_y));

  // Offsets are only captured on the IDLE->GRAB edge, so later clicks
  // during GRAB/DRAG cannot disturb them.
  assign grab_now = (state == ST_IDLE) && rect_clicked && mouse_left;

  // A release in the tick cycle wins: mouse_left must still be high.
  assign update_pos = (state == ST_DRAG) && mouse_left && frame_tick;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (grab_now)    state_nxt = ST_GRAB;
      ST_GRAB: state_nxt = mouse_left ? ST_DRAG : ST_IDLE;
      ST_DRAG: if (!mouse_left) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state    <= ST_IDLE;
      dragging <= 1'b0;
      xpos     <= COORD_W'(INIT_X);
      ypos     <= COORD_W'(INIT_Y);
      off_x    <= '0;
      off_y    <= '0;
    end else begin
      state    <= state_nxt;
      dragging <= (state_nxt == ST_DRAG);
      if (grab_now) begin
        off_x <= mouse_x_s - signed'({1'b0, xpos});
        off_y <= mouse_y_s - signed'({1'b0, ypos});
      end
      if (update_pos) begin
        xpos <= clamp_x;
        ypos <= clamp_y;
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_drag_image_ctl.sv
// tb_drag_image_ctl
//   Directed bench for drag_image_ctl. The driver applies one vector per
//   clock and, where a check is wanted, pushes the hand-computed outputs
//   into exp_q and raises chk for one cycle; the monitor pops and compares
//   on the falling edge.
module tb_drag_image_ctl;
  import drag_image_ctl_pkg::*;

  localparam int W = 27;  // {xpos, ypos, dragging, state}

  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] vcount_in, hcount_in;
  logic [11:0] xpos_mouse, ypos_mouse;
  logic        mouse_left, rect_clicked;
  logic [11:0] xpos, ypos;
  logic        dragging;
  logic [1:0]  state_dbg;

  logic         chk = 1'b0;
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           total = 0;
  int           bad   = 0;

  drag_image_ctl dut (
    .pclk(pclk), .rst(rst),
    .vcount_in(vcount_in), .hcount_in(hcount_in),
    .xpos_mouse(xpos_mouse), .ypos_mouse(ypos_mouse),
    .mouse_left(mouse_left), .rect_clicked(rect_clicked),
    .xpos(xpos), .ypos(ypos), .dragging(dragging), .state_dbg(state_dbg)
  );

  // Clock
  always #5 pclk = ~pclk;

  // Monitor / scoreboard
  always @(negedge pclk) begin
    if (chk) begin
      logic [W-1:0] e;
      string        n;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_underflow: no expected entry queued");
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if ({xpos, ypos, dragging, state_dbg} !== e) begin
          bad++;
          $display("FAIL %s: got x=%0d y=%0d drag=%0d st=%0d, want x=%0d y=%0d drag=%0d st=%0d",
                   n, xpos, ypos, dragging, state_dbg,
                   e[26:15], e[14:3], e[2], e[1:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic raster(input logic tick);
    if (tick) begin
      vcount_in = 11'd600; hcount_in = 11'd0;
    end else begin
      vcount_in = 11'd100; hcount_in = 11'd5;
    end
  endtask

  task automatic mouse(input int x, input int y, input logic left, input logic clk_hit);
    xpos_mouse   = 12'(x);
    ypos_mouse   = 12'(y);
    mouse_left   = left;
    rect_clicked = clk_hit;
  endtask

  task automatic expect_out(input string n, input int x, input int y,
                            input logic d, input drag_state_t s);
    exp_q.push_back({12'(x), 12'(y), d, 2'(s)});
    name_q.push_back(n);
    chk = 1'b1;
    @(negedge pclk);
    #1;
    chk = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    raster(1'b0);
    mouse(0, 0, 1'b0, 1'b0);
    cyc(); cyc();
    expect_out("reset", 336, 236, 1'b0, ST_IDLE);

    // Idle across two frame ticks; button without a hit does not grab.
    rst = 1'b0;
    mouse(700, 500, 1'b0, 1'b0);
    raster(1'b1); cyc(); expect_out("idle_frame1", 336, 236, 1'b0, ST_IDLE);
    raster(1'b0); cyc();
    raster(1'b1); cyc(); expect_out("idle_frame2", 336, 236, 1'b0, ST_IDLE);
    mouse(700, 500, 1'b1, 1'b0);
    cyc(); expect_out("no_hit_no_grab", 336, 236, 1'b0, ST_IDLE);

    // Grab at (400,300): offset (64,64).
    raster(1'b0);
    mouse(400, 300, 1'b1, 1'b1);
    cyc(); expect_out("grab", 336, 236, 1'b0, ST_GRAB);
    // rect_clicked still high while in GRAB must not recapture.
    mouse(500, 350, 1'b1, 1'b1);
    cyc(); expect_out("drag_entry", 336, 236, 1'b1, ST_DRAG);
    cyc(); expect_out("mid_frame_hold", 336, 236, 1'b1, ST_DRAG);
    vcount_in = 11'd600; hcount_in = 11'd1;
    cyc(); expect_out("near_tick_h1", 336, 236, 1'b1, ST_DRAG);
    vcount_in = 11'd599; hcount_in = 11'd0;
    cyc(); expect_out("near_tick_v599", 336, 236, 1'b1, ST_DRAG);
    raster(1'b1);
    cyc(); expect_out("tick_move", 436, 286, 1'b1, ST_DRAG);
    raster(1'b0); mouse(520, 360, 1'b1, 1'b0);
    cyc(); expect_out("hold_after_tick", 436, 286, 1'b1, ST_DRAG);

    // Clamp cases, each on a tick.
    raster(1'b1);
    mouse(10, 5, 1'b1, 1'b0);    cyc(); expect_out("clamp_low", 0, 0, 1'b1, ST_DRAG);
    mouse(900, 700, 1'b1, 1'b0); cyc(); expect_out("clamp_high", 672, 472, 1'b1, ST_DRAG);
    mouse(735, 535, 1'b1, 1'b0); cyc(); expect_out("below_max", 671, 471, 1'b1, ST_DRAG);
    mouse(64, 64, 1'b1, 1'b0);   cyc(); expect_out("exact_zero", 0, 0, 1'b1, ST_DRAG);
    mouse(65, 300, 1'b1, 1'b0);  cyc(); expect_out("in_range", 1, 236, 1'b1, ST_DRAG);

    // Release in the tick cycle: no update.
    mouse(500, 350, 1'b0, 1'b0); cyc(); expect_out("release_on_tick", 1, 236, 1'b0, ST_IDLE);
    cyc(); expect_out("stay_idle", 1, 236, 1'b0, ST_IDLE);

    // Button released during GRAB aborts to IDLE.
    raster(1'b0);
    mouse(100, 300, 1'b1, 1'b1); cyc(); expect_out("grab2", 1, 236, 1'b0, ST_GRAB);
    mouse(100, 300, 1'b0, 1'b0); cyc(); expect_out("grab_abort", 1, 236, 1'b0, ST_IDLE);

    // Drag with offset (99,64), then reset mid-drag.
    mouse(100, 300, 1'b1, 1'b1); cyc();
    mouse(100, 300, 1'b1, 1'b0); cyc(); expect_out("drag3", 1, 236, 1'b1, ST_DRAG);
    raster(1'b1); mouse(300, 400, 1'b1, 1'b0);
    cyc(); expect_out("drag3_move", 201, 336, 1'b1, ST_DRAG);
    raster(1'b0); rst = 1'b1;
    cyc(); expect_out("reset_mid_drag", 336, 236, 1'b0, ST_IDLE);
    rst = 1'b0; raster(1'b1); mouse(600, 400, 1'b1, 1'b0);
    cyc(); expect_out("after_reset_held", 336, 236, 1'b0, ST_IDLE);
    cyc(); expect_out("after_reset_held2", 336, 236, 1'b0, ST_IDLE);

    // Fresh drag, then release off-tick.
    raster(1'b0);
    mouse(400, 300, 1'b1, 1'b1); cyc();
    mouse(400, 300, 1'b1, 1'b0); cyc(); expect_out("drag4", 336, 236, 1'b1, ST_DRAG);
    mouse(400, 300, 1'b0, 1'b0); cyc(); expect_out("release_off_tick", 336, 236, 1'b0, ST_IDLE);

    // Drain: any entry left unchecked counts as a failure.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) cyc();
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expected entries unchecked, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
